prio_req_encoder: RTL and testbench
===================================

PRIO_REQ_ENCODER -- requirements
Module: prio_req_encoder

Interface
REQ-001 Parameter N, default 8, number of request channels (legal 2..64).
REQ-002 Parameter W, default $clog2(N), index width, derived and not overridden.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 En  input  1  capture enable for new requests.
REQ-006 req  input  N  request lines; bit i is channel i.
REQ-007 out_valid  output  1  encoded index presented.
REQ-008 out_ready  input  1  consumer accepts out_idx this cycle.
REQ-009 out_idx  output  W  index of the granted channel.
REQ-010 pending  output  N  latched outstanding requests.
REQ-011 pend_cnt  output  W+1  population count of pending.

Function
REQ-012 pending[i] SHALL be set on the edge when En=1 and req[i]=1, and held until its grant is accepted.
REQ-013 With En=0, req SHALL be ignored; pending and the handshake continue unaffected.
REQ-014 Priority SHALL be fixed: the highest pending index wins.
REQ-015 FSM states: IDLE (out_valid=0) and HOLD (out_valid=1).
REQ-016 IDLE -> HOLD when pending is nonzero; out_idx is loaded with the winner from registered pending; the winner is not visible in the same cycle as its request.
REQ-017 Latency: req asserted in cycle t with an empty pipeline SHALL give out_valid=1 in cycle t+2.
REQ-018 HOLD with out_ready=0: out_idx and out_valid SHALL stay stable, even when a higher-priority request arrives.
REQ-019 HOLD with out_ready=1: pending[out_idx] is cleared. If other pending bits remain, excluding the cleared one, the next winner loads and the FSM stays in HOLD (back-to-back, one grant per cycle). Otherwise -> IDLE.
REQ-020 Simultaneous set and clear of the same bit SHALL leave the bit set; the channel is re-granted later.
REQ-021 A repeated request on an already-pending bit SHALL be absorbed; no counting and no error.
REQ-022 out_idx SHALL be 0 whenever out_valid=0; X values are never driven.
REQ-023 pend_cnt SHALL equal the popcount of the registered pending, same-cycle.

Reset
REQ-024 When rst_n=0 at an edge: pending=0, state=IDLE, out_valid=0, out_idx=0, pend_cnt=0, rotation pointer=0.
REQ-025 Reset mid-HOLD SHALL discard the outstanding grant and all pending requests; req is not captured during the reset cycle.

Configuration
REQ-026 Macro PRIO_ENC_RR_EN, when defined, SHALL enable round-robin priority. After accepting grant k, the search starts at index (k-1) mod N and proceeds downward with wrap. The pointer only updates on acceptance.
REQ-027 Without PRIO_ENC_RR_EN, priority is fixed per REQ-014 and the rotation pointer is not present.
REQ-028 With the pointer at reset value 0, the first RR search starts at N-1, identical to fixed priority.

Structure
REQ-029 Package prio_enc_pkg SHALL hold the FSM state enum (IDLE, HOLD) and a popcount function.
REQ-030 Sub-module prio_find: combinational; inputs mask[N] and start index; outputs found and idx. It is the only search logic and is shared by both modes.

Verification (N=8)
REQ-031 req=8'b0000_0101 for 1 cycle, En=1, out_ready=1 -> out_idx=2 at t+2, then 0 at t+3; pend_cnt 2->1->0; then IDLE.
REQ-032 req=8'h01 latched, out_ready=0; then req=8'h80 -> out_idx stays 0 until accepted, next grant 7.
REQ-033 En=0 with req=8'hFF for 5 cycles -> pending=0 and out_valid=0 throughout.
REQ-034 Grant 3 accepted in the same cycle as req[3]=1 -> pending[3] stays 1 and channel 3 is granted again.
REQ-035 HOLD with pending=8'h0C, rst_n=0 for one cycle -> all outputs 0 next cycle; IDLE.
REQ-036 PRIO_ENC_RR_EN, req=8'hFF held, out_ready=1 -> grants 7,6,5,...,0,7 in consecutive cycles; in fixed mode, grants 7 repeatedly.

Source files
------------

// File: rtl/prio_enc_pkg.sv
// Shared types and helpers for the priority request encoder.
// Round-robin mode is selected by defining PRIO_ENC_RR_EN.
package prio_enc_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam int MAX_N = 64;

   function automatic int unsigned popcount(input logic [MAX_N-1:0] v);
      int unsigned c;
      c = 0;
      for (int i = 0; i < MAX_N; i++) begin
         if (v[i]) c++;
      end
      return c;
   endfunction

endpackage

// File: rtl/prio_find.sv
// Combinational downward search with wrap: first set mask bit at or below start.
// Shared by fixed and round-robin priority (PRIO_ENC_RR_EN).
module prio_find #(
   parameter int N = 8,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] mask,
   input  logic [W-1:0] start,
   output logic         found,
   output logic [W-1:0] idx
);

   function automatic logic [W-1:0] wrap_sub(input logic [W-1:0] s, input int k);
      return W'((int'(s) + N - k) % N);
   endfunction

   // Iterate from the farthest position back to start so the nearest hit wins.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (mask[wrap_sub(start, k)]) begin
            found = 1'b1;
            idx   = wrap_sub(start, k);
         end
      end
   end

endmodule

// File: rtl/prio_req_encoder.sv
// Latches requests and grants them one at a time through a valid/ready handshake.
// Fixed highest-index priority by default; PRIO_ENC_RR_EN enables round-robin.
module prio_req_encoder
   import prio_enc_pkg::*;
#(
   parameter int N = 8,
   parameter int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         En,
   input  logic [N-1:0] req,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_idx,
   output logic [N-1:0] pending,
   output logic [W:0]   pend_cnt
);

   state_t       state;
   logic [N-1:0] set_vec;
   logic [N-1:0] clr_vec;
   logic [N-1:0] search_mask;
   logic [W-1:0] search_start;
   logic         accept;
   logic         find_found;
   logic [W-1:0] find_idx;

   function automatic logic [W-1:0] dec_wrap(input logic [W-1:0] x);
      return W'((int'(x) + N - 1) % N);
   endfunction

   assign set_vec = En ? req : '0;
   assign accept  = (state == HOLD) && out_ready;
   assign clr_vec = accept ? (N'(1) << out_idx) : '0;

   // A re-requested granted bit stays eligible; fresh requests wait one cycle.
   assign search_mask = accept ? (pending & ~(clr_vec & ~set_vec)) : pending;

`ifdef PRIO_ENC_RR_EN
   logic [W-1:0] rr_ptr;

   assign search_start = accept ? dec_wrap(out_idx) : dec_wrap(rr_ptr);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (accept) begin
         rr_ptr <= out_idx;
      end
   end
`else
   assign search_start = W'(N - 1);
`endif

   prio_find #(.N(N), .W(W)) u_find (
      .mask  (search_mask),
      .start (search_start),
      .found (find_found),
      .idx   (find_idx)
   );

   assign pend_cnt = (W+1)'(popcount(MAX_N'(pending)));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         pending   <= '0;
         out_valid <= 1'b0;
         out_idx   <= '0;
      end else begin
         pending <= (pending & ~clr_vec) | set_vec;
         case (state)
            IDLE: begin
               if (find_found) begin
                  state     <= HOLD;
                  out_valid <= 1'b1;
                  out_idx   <= find_idx;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  if (find_found) begin
                     out_idx <= find_idx;
                  end else begin
                     state     <= IDLE;
                     out_valid <= 1'b0;
                     out_idx   <= '0;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               out_idx   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prio_req_encoder.sv
// Self-checking bench for prio_req_encoder (N=8), fixed or PRIO_ENC_RR_EN mode.
module tb_prio_req_encoder;

   localparam int N = 8;
   localparam int W = $clog2(N);
`ifdef PRIO_ENC_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         En;
   logic [N-1:0] req;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_idx;
   logic [N-1:0] pending;
   logic [W:0]   pend_cnt;

   int checks = 0;
   int errors = 0;

   // Reference state: latched requests, grant presented, last accepted index.
   logic [N-1:0] mp;
   bit           mv;
   int           mi;
   int           mptr;

   always #5 clk = ~clk;

   prio_req_encoder #(.N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .En        (En),
      .req       (req),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .pending   (pending),
      .pend_cnt  (pend_cnt)
   );

   function automatic int pick(input int start, input logic [N-1:0] m);
      for (int k = 0; k < N; k++) begin
         if (m[(start - k + N) % N]) return (start - k + N) % N;
      end
      return 0;
   endfunction

   function automatic int popc(input logic [N-1:0] v);
      int c = 0;
      for (int i = 0; i < N; i++) c += int'(v[i]);
      return c;
   endfunction

   task automatic step();
      logic [N-1:0] newp;
      logic [N-1:0] cand;
      bit nv;
      int ni;
      int np;
      int start;
      nv = mv; ni = mi; np = mptr; newp = mp;
      if (!rst_n) begin
         newp = '0; nv = 1'b0; ni = 0; np = 0;
      end else begin
         if (mv && out_ready) newp[mi] = 1'b0;
         if (En) newp = newp | req;
         if (!mv) begin
            if (mp != '0) begin
               start = RR ? (mptr + N - 1) % N : N - 1;
               nv = 1'b1;
               ni = pick(start, mp);
            end
         end else if (out_ready) begin
            cand  = mp & newp;
            start = RR ? (mi + N - 1) % N : N - 1;
            if (RR) np = mi;
            if (cand != '0) ni = pick(start, cand);
            else begin nv = 1'b0; ni = 0; end
         end
      end
      @(posedge clk);
      #1;
      mp = newp; mv = nv; mi = ni; mptr = np;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; En = 1'b0; req = '0; out_ready = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
      checks++; if (out_idx !== '0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", out_idx); end
      checks++; if (pending !== '0) begin errors++; $display("FAIL reset_pending: got %0h expected 0", pending); end
      checks++; if (pend_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", pend_cnt); end
   endtask

   task automatic test_basic_latency();
      logic [N-1:0] exp_p [4] = '{8'h05, 8'h05, 8'h01, 8'h00};
      bit           exp_v [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      int           exp_i [4] = '{0, 2, 0, 0};
      int           exp_c [4] = '{2, 2, 1, 0};
      do_reset();
      out_ready = 1'b1; En = 1'b1; req = 8'h05;
      for (int c = 0; c < 4; c++) begin
         step();
         req = '0;
         checks++; if (out_valid !== exp_v[c]) begin errors++; $display("FAIL latency_valid c%0d: got %0b expected %0b", c, out_valid, exp_v[c]); end
         checks++; if (out_idx !== W'(exp_i[c])) begin errors++; $display("FAIL latency_idx c%0d: got %0d expected %0d", c, out_idx, exp_i[c]); end
         checks++; if (pending !== exp_p[c]) begin errors++; $display("FAIL latency_pending c%0d: got %0h expected %0h", c, pending, exp_p[c]); end
         checks++; if (pend_cnt !== (W+1)'(exp_c[c])) begin errors++; $display("FAIL latency_cnt c%0d: got %0d expected %0d", c, pend_cnt, exp_c[c]); end
      end
   endtask

   task automatic test_hold_stable();
      do_reset();
      En = 1'b1; out_ready = 1'b0; req = 8'h01;
      step();
      req = '0;
      step();
      req = 8'h80;
      step();
      req = '0;
      for (int c = 0; c < 3; c++) begin
         checks++; if (out_valid !== 1'b1 || out_idx !== W'(0)) begin errors++; $display("FAIL hold_stable c%0d: got valid=%0b idx=%0d expected valid=1 idx=0", c, out_valid, out_idx); end
         step();
      end
      checks++; if (pending !== 8'h81) begin errors++; $display("FAIL hold_pending: got %0h expected 81", pending); end
      out_ready = 1'b1;
      step();
      checks++; if (out_valid !== 1'b1 || out_idx !== W'(7)) begin errors++; $display("FAIL hold_next: got valid=%0b idx=%0d expected valid=1 idx=7", out_valid, out_idx); end
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_drain: got %0b expected 0", out_valid); end
   endtask

   task automatic test_enable_low();
      do_reset();
      En = 1'b0; req = 8'hFF; out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         checks++; if (pending !== '0 || out_valid !== 1'b0) begin errors++; $display("FAIL en_low c%0d: got pending=%0h valid=%0b expected 0 0", c, pending, out_valid); end
      end
      req = '0;
   endtask

   task automatic test_same_cycle_set_clear();
      do_reset();
      En = 1'b1; out_ready = 1'b0; req = 8'h08;
      step();
      req = '0;
      step();
      checks++; if (out_idx !== W'(3) || out_valid !== 1'b1) begin errors++; $display("FAIL setclr_grant: got idx=%0d valid=%0b expected 3 1", out_idx, out_valid); end
      out_ready = 1'b1; req = 8'h08;
      step();
      req = '0;
      checks++; if (pending !== 8'h08) begin errors++; $display("FAIL setclr_pending: got %0h expected 08", pending); end
      checks++; if (out_idx !== W'(3) || out_valid !== 1'b1) begin errors++; $display("FAIL setclr_regrant: got idx=%0d valid=%0b expected 3 1", out_idx, out_valid); end
      step();
      checks++; if (out_valid !== 1'b0 || pending !== '0) begin errors++; $display("FAIL setclr_drain: got valid=%0b pending=%0h expected 0 0", out_valid, pending); end
   endtask

   task automatic test_reset_mid_hold();
      do_reset();
      En = 1'b1; out_ready = 1'b0; req = 8'h0C;
      step();
      req = '0;
      step();
      checks++; if (out_idx !== W'(3) || pending !== 8'h0C) begin errors++; $display("FAIL midrst_setup: got idx=%0d pending=%0h expected 3 0c", out_idx, pending); end
      rst_n = 1'b0; req = 8'hFF;
      step();
      rst_n = 1'b1; req = '0;
      checks++; if (out_valid !== 1'b0 || out_idx !== '0 || pending !== '0 || pend_cnt !== '0) begin
         errors++; $display("FAIL midrst_clear: got valid=%0b idx=%0d pending=%0h cnt=%0d expected all 0", out_valid, out_idx, pending, pend_cnt);
      end
      step();
      checks++; if (out_valid !== 1'b0 || pending !== '0) begin errors++; $display("FAIL midrst_nocapture: got valid=%0b pending=%0h expected 0 0", out_valid, pending); end
   endtask

   task automatic test_back_to_back();
      int n;
      int exp;
      do_reset();
      En = 1'b1; out_ready = 1'b1; req = 8'hFF;
      step();
      step();
      for (int g = 0; g < 10; g++) begin
         exp = RR ? (7 - (g % N)) : 7;
         checks++; if (out_valid !== 1'b1 || out_idx !== W'(exp)) begin errors++; $display("FAIL b2b_grant g%0d: got valid=%0b idx=%0d expected 1 %0d", g, out_valid, out_idx, exp); end
         step();
      end
      En = 1'b0; req = '0;
      n = 0;
      while (out_valid === 1'b1 && n < 64) begin step(); n++; end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got valid=%0b after %0d cycles expected 0", out_valid, n); end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         rst_n     = ($urandom_range(0, 39) != 0);
         En        = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         req       = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
         step();
         checks++; if (pending !== mp) begin errors++; $display("FAIL rnd_pending c%0d: got %0h expected %0h", c, pending, mp); end
         checks++; if (out_valid !== mv) begin errors++; $display("FAIL rnd_valid c%0d: got %0b expected %0b", c, out_valid, mv); end
         checks++; if (out_idx !== W'(mi)) begin errors++; $display("FAIL rnd_idx c%0d: got %0d expected %0d", c, out_idx, mi); end
         checks++; if (pend_cnt !== (W+1)'(popc(mp))) begin errors++; $display("FAIL rnd_cnt c%0d: got %0d expected %0d", c, pend_cnt, popc(mp)); end
      end
      rst_n = 1'b1;
   endtask

   initial begin
      mp = '0; mv = 1'b0; mi = 0; mptr = 0;
      rst_n = 1'b0; En = 1'b0; req = '0; out_ready = 1'b0;
      test_reset();
      test_basic_latency();
      test_hold_stable();
      test_enable_low();
      test_same_cycle_set_clear();
      test_reset_mid_hold();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
